// File: rtl/bcd_digit_streamer.sv
// Binary-to-BCD converter (shift-add-3, one bit per cycle) that streams digits LSD first
// onto the seven-segment controller's dig/pos write port. Optional macro: SIGNED_EN.
module bcd_digit_streamer #(
  parameter int WIDTH = 27,
  parameter int NDIG  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic [3:0]       dig,
  output logic [3:0]       pos,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             neg
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

  localparam logic [63:0] LIMIT = pow10_m1(NDIG);

  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < NDIG; i++) begin
      if (b[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = b[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = b[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t           state_r, state_n;
  logic [WIDTH-1:0] shreg_r, shreg_n;
  logic [BW-1:0]    bcd_r, bcd_n;
  logic [CW-1:0]    cnt_r, cnt_n;
  logic [3:0]       idx_r, idx_n;
  logic [3:0]       dig_r, dig_n;
  logic [3:0]       pos_r, pos_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             ovf_r, ovf_n;
  logic             neg_r, neg_n;

  logic [WIDTH:0]   mag_s;
  logic             sign_s;
  logic [BW-1:0]    sum_s;
  logic [BW-1:0]    emit_s;

  // Next-state and next-output logic for the convert/emit sequencer.
  always_comb begin
    state_n = state_r;
    shreg_n = shreg_r;
    bcd_n   = bcd_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    dig_n   = 4'hF;
    pos_n   = 4'hF;
    done_n  = 1'b0;
    ovf_n   = ovf_r;
    neg_n   = neg_r;
    sum_s   = add3_all(bcd_r);
    emit_s  = bcd_r >> {idx_r, 2'b00};
`ifdef SIGNED_EN
    sign_s = value[WIDTH-1];
    // One extra bit so the most negative input negates exactly.
    if (sign_s) begin
      mag_s = ~{value[WIDTH-1], value} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      mag_s = {1'b0, value};
    end
`else
    sign_s = 1'b0;
    mag_s  = {1'b0, value};
`endif

    case (state_r)
      IDLE: begin
        if (start) begin
          shreg_n = mag_s[WIDTH-1:0];
          neg_n   = sign_s;
          idx_n   = 4'd0;
          if ({{(63-WIDTH){1'b0}}, mag_s} > LIMIT) begin
            ovf_n   = 1'b1;
            bcd_n   = {NDIG{4'h9}};
            state_n = EMIT;
          end else begin
            ovf_n   = 1'b0;
            bcd_n   = {BW{1'b0}};
            cnt_n   = CW'(WIDTH - 1);
            state_n = CONV;
          end
        end else begin
          state_n = IDLE;
        end
      end
      CONV: begin
        bcd_n   = {sum_s[BW-2:0], shreg_r[WIDTH-1]};
        shreg_n = {shreg_r[WIDTH-2:0], 1'b0};
        if (cnt_r == {CW{1'b0}}) begin
          idx_n   = 4'd0;
          state_n = EMIT;
        end else begin
          cnt_n   = cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      EMIT: begin
        dig_n = emit_s[3:0];
        pos_n = idx_r;
        if (idx_r == 4'(NDIG - 1)) begin
          state_n = DONE;
        end else begin
          idx_n = idx_r + 4'd1;
        end
      end
      DONE: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == CONV) || (state_n == EMIT);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      shreg_r <= {WIDTH{1'b0}};
      bcd_r   <= {BW{1'b0}};
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 4'd0;
      dig_r   <= 4'hF;
      pos_r   <= 4'hF;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      ovf_r   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      shreg_r <= shreg_n;
      bcd_r   <= bcd_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      dig_r   <= dig_n;
      pos_r   <= pos_n;
      busy_r  <= busy_n;
      done_r  <= done_n;
      ovf_r   <= ovf_n;
      neg_r   <= neg_n;
    end
  end

  assign dig  = dig_r;
  assign pos  = pos_r;
  assign busy = busy_r;
  assign done = done_r;
  assign ovf  = ovf_r;
  assign neg  = neg_r;

endmodule
